uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between NUM_REQ byte producers, such as the receive-echo path and the buffered-message sender. Requesters use a valid/ready byte handshake. The arbiter grants round-robin, locks the grant for a whole message until the byte marked last has been sent, and sequences the UART transmit/is_transmitting handshake. It sits between the requesters and the uart instance, driving its transmit and tx_byte inputs.

---
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locked sharing of one UART transmitter
// between NUM_REQ valid/ready byte producers. Rev 1.0
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_byte,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 transmit,
  output logic [7:0]           tx_byte,
  input  logic                 is_transmitting,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t             state;
  logic               lock;
  logic               last_flag;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   last_owner;
  logic [CNT_W-1:0]   wait_cnt;

  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic               sel_found;
  logic [7:0]         sel_byte;

  // Descending scan so the nearest requester after last_owner is assigned last and wins.
  always_comb begin
    sel_idx   = '0;
    cand_idx  = '0;
    sel_found = 1'b0;
    if (lock) begin
      sel_idx   = owner;
      sel_found = req_valid[owner];
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        cand_idx = IDX_W'((int'(last_owner) + k) % NUM_REQ);
        if (req_valid[cand_idx]) begin
          sel_idx   = cand_idx;
          sel_found = 1'b1;
        end
      end
    end
  end

  assign sel_byte  = req_byte[{sel_idx, 3'b000} +: 8];
  assign req_ready = (reset && state == S_IDLE && sel_found) ?
                     (NUM_REQ'(1) << sel_idx) : '0;
  assign busy      = (state != S_IDLE) || lock;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      tx_byte     <= 8'h00;
      grant       <= '0;
      lock        <= 1'b0;
      last_flag   <= 1'b0;
      owner       <= '0;
      last_owner  <= IDX_W'(NUM_REQ - 1);
      wait_cnt    <= '0;
      transmit    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            tx_byte   <= sel_byte;
            grant     <= NUM_REQ'(1) << sel_idx;
            owner     <= sel_idx;
            lock      <= ~req_last[sel_idx];
            last_flag <= req_last[sel_idx];
            wait_cnt  <= '0;
            transmit  <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (is_transmitting) begin
            wait_cnt <= '0;
            transmit <= 1'b0;
            state    <= S_SEND;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // UART never answered: drop the byte and free the transmitter.
            timeout_err <= 1'b1;
            wait_cnt    <= '0;
            transmit    <= 1'b0;
            lock        <= 1'b0;
            last_owner  <= owner;
            grant       <= '0;
            state       <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_SEND: begin
          if (!is_transmitting) begin
            state <= S_IDLE;
            if (last_flag) begin
              lock       <= 1'b0;
              last_owner <= owner;
              grant      <= '0;
            end
          end
        end
        default: begin
          transmit <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a behavioural UART that answers transmit.
// Rev 1.0
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int TO   = 8;
  localparam int HOLD = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_byte;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic        transmit;
  logic [7:0]  tx_byte;
  logic        is_transmitting;
  logic        busy;
  logic        timeout_err;

  uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_byte(req_byte),
    .req_last(req_last), .req_ready(req_ready), .grant(grant),
    .transmit(transmit), .tx_byte(tx_byte), .is_transmitting(is_transmitting),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic       hold0;
  logic       mute;

  int         r0_cnt, r1_cnt, tx_cycles, to_cnt, r0_first;
  logic [1:0] first_grant;

  // UART model: latches the byte on the first edge it sees transmit, then stays busy HOLD cycles.
  logic u_active;
  int   u_hold;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_transmitting <= 1'b0;
      u_active        <= 1'b0;
      u_hold          <= 0;
    end else if (!mute) begin
      if (!u_active && transmit) begin
        u_active        <= 1'b1;
        is_transmitting <= 1'b1;
        u_hold          <= 0;
        obs_q.push_back(tx_byte);
      end else if (u_active) begin
        if (u_hold == HOLD - 1) begin
          is_transmitting <= 1'b0;
          u_active        <= 1'b0;
        end else begin
          u_hold <= u_hold + 1;
        end
      end
    end
  end

  task automatic reload();
    req_valid[0] = (q0.size() > 0) && !hold0;
    if (q0.size() > 0) begin
      req_byte[7:0] = q0[0][7:0];
      req_last[0]   = q0[0][8];
    end
    req_valid[1] = (q1.size() > 0);
    if (q1.size() > 0) begin
      req_byte[15:8] = q1[0][7:0];
      req_last[1]    = q1[0][8];
    end
  endtask

  task automatic clear_stats();
    r0_cnt = 0; r1_cnt = 0; tx_cycles = 0; to_cnt = 0; r0_first = -1;
    first_grant = 2'b00;
  endtask

  task automatic step();
    logic a0, a1;
    @(negedge clk);
    a0 = req_ready[0] & req_valid[0];
    a1 = req_ready[1] & req_valid[1];
    if (req_ready[0]) begin
      r0_cnt++;
      if (r0_first < 0) r0_first = obs_q.size();
    end
    if (req_ready[1]) r1_cnt++;
    if (transmit) tx_cycles++;
    if (timeout_err) to_cnt++;
    if (grant != 2'b00 && first_grant == 2'b00) first_grant = grant;
    @(posedge clk);
    #1;
    if (a0 && q0.size() > 0) q0.delete(0);
    if (a1 && q1.size() > 0) q1.delete(0);
    reload();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    q0.delete(); q1.delete(); exp_q.delete(); obs_q.delete();
    hold0 = 1'b0;
    mute  = 1'b0;
    reload();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    clear_stats();
  endtask

  task automatic drain(input string name, input int budget);
    logic [7:0] e, o;
    for (int i = 0; i < budget; i++) begin
      step();
      if (obs_q.size() >= exp_q.size() && !busy && !is_transmitting) break;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s byte: got none, expected %h", name, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s byte: got %h, expected %h", name, o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL %s extra bytes: got %0d, expected 0", name, obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    mute      = 1'b0;
    hold0     = 1'b0;
    req_valid = 2'b11;
    req_byte  = 16'h6130;
    req_last  = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset req_ready: got %b, expected 00", req_ready); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset grant: got %b, expected 00", grant); end
    checks++; if (transmit !== 1'b0) begin errors++; $display("FAIL reset transmit: got %b, expected 0", transmit); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset tx_byte: got %h, expected 00", tx_byte); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b, expected 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset timeout_err: got %b, expected 0", timeout_err); end
  endtask

  task automatic test_single_byte();
    logic [7:0] seen_byte;
    do_reset();
    seen_byte = 8'h00;
    q0.push_back({1'b1, 8'h41});
    exp_q.push_back(8'h41);
    reload();
    for (int i = 0; i < 40; i++) begin
      step();
      if (transmit) seen_byte = tx_byte;
      if (obs_q.size() >= 1 && !busy && !is_transmitting) break;
    end
    checks++; if (r0_cnt != 1) begin errors++; $display("FAIL single req_ready pulses: got %0d, expected 1", r0_cnt); end
    checks++; if (tx_cycles != 2) begin errors++; $display("FAIL single transmit cycles: got %0d, expected 2", tx_cycles); end
    checks++; if (seen_byte !== 8'h41) begin errors++; $display("FAIL single tx_byte: got %h, expected 41", seen_byte); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single grant after: got %b, expected 00", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single busy after: got %b, expected 0", busy); end
    drain("single", 10);
  endtask

  task automatic test_round_robin();
    do_reset();
    q0.push_back({1'b1, 8'h30}); q0.push_back({1'b1, 8'h30});
    q1.push_back({1'b1, 8'h61}); q1.push_back({1'b1, 8'h61});
    exp_q.push_back(8'h30); exp_q.push_back(8'h61);
    exp_q.push_back(8'h30); exp_q.push_back(8'h61);
    reload();
    drain("round_robin", 300);
    checks++; if (first_grant !== 2'b01) begin errors++; $display("FAIL rr first grant: got %b, expected 01", first_grant); end
  endtask

  task automatic test_message_lock();
    do_reset();
    q1.push_back({1'b0, 8'h48}); q1.push_back({1'b0, 8'h49}); q1.push_back({1'b1, 8'h21});
    exp_q.push_back(8'h48); exp_q.push_back(8'h49); exp_q.push_back(8'h21); exp_q.push_back(8'h58);
    reload();
    for (int i = 0; i < 20 && r1_cnt == 0; i++) step();
    q0.push_back({1'b1, 8'h58});
    reload();
    drain("lock", 300);
    checks++; if (r0_first != 3) begin errors++; $display("FAIL lock req0 ready after bytes: got %0d, expected 3", r0_first); end
  endtask

  task automatic test_timeout();
    do_reset();
    mute = 1'b1;
    q0.push_back({1'b0, 8'hA5});
    reload();
    for (int i = 0; i < 40 && to_cnt == 0; i++) step();
    checks++; if (tx_cycles != TO) begin errors++; $display("FAIL timeout wait cycles: got %0d, expected %0d", tx_cycles, TO); end
    repeat (3) step();
    checks++; if (to_cnt != 1) begin errors++; $display("FAIL timeout pulses: got %0d, expected 1", to_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout busy: got %b, expected 0", busy); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL timeout grant: got %b, expected 00", grant); end
    mute = 1'b0;
    first_grant = 2'b00;
    q1.push_back({1'b1, 8'h5A});
    q0.push_back({1'b1, 8'hC3});
    exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
    reload();
    drain("timeout", 200);
    checks++; if (first_grant !== 2'b10) begin errors++; $display("FAIL timeout next grant: got %b, expected 10", first_grant); end
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    q0.push_back({1'b0, 8'h11}); q0.push_back({1'b1, 8'h22});
    reload();
    for (int i = 0; i < 30; i++) begin
      step();
      if (is_transmitting && !transmit && obs_q.size() == 1) break;
    end
    checks++; if (obs_q.size() != 1 || obs_q[0] !== 8'h11) begin errors++; $display("FAIL midreset first byte: got %0d bytes, expected one 11", obs_q.size()); end
    reset = 1'b0;
    #1;
    checks++; if (transmit !== 1'b0) begin errors++; $display("FAIL midreset transmit: got %b, expected 0", transmit); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL midreset grant: got %b, expected 00", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset busy: got %b, expected 0", busy); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL midreset req_ready: got %b, expected 00", req_ready); end
    q0.delete(); q1.delete(); obs_q.delete(); exp_q.delete();
    reload();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    clear_stats();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset busy after release: got %b, expected 0", busy); end
    q0.push_back({1'b1, 8'h66});
    q1.push_back({1'b1, 8'h77});
    exp_q.push_back(8'h66); exp_q.push_back(8'h77);
    reload();
    drain("midreset", 200);
    checks++; if (first_grant !== 2'b01) begin errors++; $display("FAIL midreset first grant: got %b, expected 01", first_grant); end
  endtask

  task automatic test_stall();
    int bad;
    do_reset();
    q0.push_back({1'b0, 8'hD1}); q0.push_back({1'b1, 8'hD2});
    exp_q.push_back(8'hD1); exp_q.push_back(8'hD2); exp_q.push_back(8'hE1);
    reload();
    for (int i = 0; i < 20 && r0_cnt == 0; i++) step();
    hold0 = 1'b1;
    q1.push_back({1'b1, 8'hE1});
    reload();
    r1_cnt = 0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (grant !== 2'b01 || busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall grant/busy held: got %0d bad cycles, expected 0", bad); end
    checks++; if (r1_cnt != 0) begin errors++; $display("FAIL stall req1 ready: got %0d, expected 0", r1_cnt); end
    hold0 = 1'b0;
    reload();
    drain("stall", 200);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL stall final grant: got %b, expected 00", grant); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 2'b00;
    req_byte  = 16'h0000;
    req_last  = 2'b00;
    hold0     = 1'b0;
    mute      = 1'b0;
    reset     = 1'b0;
    clear_stats();
    test_reset();
    test_single_byte();
    test_round_robin();
    test_message_lock();
    test_timeout();
    test_reset_mid_send();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
